// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg
//   Shared types for the ALU scheduler: FSM state encoding, ALU opcode
//   encoding and a small modular-increment helper for the round-robin pointer.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

  // (v + 1) mod n, for a pointer that wraps from n-1 back to 0
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    int unsigned r;
    if ((v + 32'd1) >= n) begin
      r = 32'd0;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first asserted request at
//   or after the start pointer, wrapping modulo N.
//   Ports:
//     i_req    [N]      request vector
//     i_start  [IDX_W]  highest-priority index
//     o_found  1        at least one request asserted
//     o_idx    [IDX_W]  winning index (0 when nothing found)
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // start + ofs modulo N; ofs is always below N so one subtraction suffices
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= 32'(N)) begin
      sum = sum - 32'(N);
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  // Scan from the lowest priority offset upwards so the nearest hit wins last
  always_comb begin
    o_found = 1'b0;
    o_idx   = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[wrap_idx(i_start, i)]) begin
        o_found = 1'b1;
        o_idx   = wrap_idx(i_start, i);
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched
//   Shares one floating-point ALU (one op in flight) among NUM_REQ requesters
//   with round-robin arbitration. Each op walks IDLE -> ISSUE -> WAIT -> RESP.
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     req_valid/ready          per-requester request handshake (ready one-hot)
//     req_a, req_b, req_op     per-requester operands and op (0 add, 1 mul)
//     rsp_valid/ready          per-requester response handshake (valid one-hot)
//     rsp_data                 shared result bus, qualified by rsp_valid
//     alu_a, alu_b, alu_op     operands to the ALU
//     alu_valid/ready          ALU request handshake
//     alu_result               ALU result
//     alu_res_valid/ready      ALU result handshake
//   req_ready is combinational from req_valid and the round-robin pointer;
//   every other output comes straight from a register.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]              req_op,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [WIDTH-1:0]                rsp_data,
  output logic [WIDTH-1:0]                alu_a,
  output logic [WIDTH-1:0]                alu_b,
  output logic                            alu_op,
  output logic                            alu_valid,
  input  logic                            alu_ready,
  input  logic [WIDTH-1:0]                alu_result,
  input  logic                            alu_res_valid,
  output logic                            alu_res_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  sched_state_t         r_state;
  sched_state_t         w_next_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_grant;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  alu_op_t              r_op;
  logic [WIDTH-1:0]     r_res;
  logic                 r_alu_valid;
  logic                 r_alu_res_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;

  logic                 w_found;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_req_hs;
  logic                 w_rsp_hs;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_winner)
  );

  // Next-state logic, request grant and handshake detection
  always_comb begin
    w_next_state = r_state;
    w_req_hs     = 1'b0;
    w_rsp_hs     = 1'b0;
    req_ready    = {NUM_REQ{1'b0}};
    case (r_state)
      IDLE: begin
        // ready is derived from valid, so a found winner is always a handshake
        if (w_found) begin
          req_ready    = ONE_HOT0 << w_winner;
          w_req_hs     = 1'b1;
          w_next_state = ISSUE;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE: begin
        if (alu_ready) begin
          w_next_state = WAIT;
        end else begin
          w_next_state = ISSUE;
        end
      end
      WAIT: begin
        if (alu_res_valid) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP: begin
        // only the granted requester's rsp_ready matters
        if (rsp_ready[r_grant]) begin
          w_rsp_hs     = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, operand/result registers, pointer and registered output decodes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_rr_ptr        <= {IDX_W{1'b0}};
      r_grant         <= {IDX_W{1'b0}};
      r_op_a          <= {WIDTH{1'b0}};
      r_op_b          <= {WIDTH{1'b0}};
      r_op            <= OP_ADD;
      r_res           <= {WIDTH{1'b0}};
      r_alu_valid     <= 1'b0;
      r_alu_res_ready <= 1'b0;
      r_rsp_valid     <= {NUM_REQ{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_req_hs) begin
        r_op_a  <= req_a[w_winner];
        r_op_b  <= req_b[w_winner];
        r_op    <= alu_op_t'(req_op[w_winner]);
        r_grant <= w_winner;
      end else begin
        r_grant <= r_grant;
      end
      if ((r_state == WAIT) && alu_res_valid) begin
        r_res <= alu_result;
      end else begin
        r_res <= r_res;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= IDX_W'(wrap_inc(32'(r_grant), NUM_REQ));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
      r_alu_valid     <= (w_next_state == ISSUE);
      r_alu_res_ready <= (w_next_state == WAIT);
      // the grant never changes on the way into RESP, so r_grant is current
      r_rsp_valid     <= (w_next_state == RESP) ? (ONE_HOT0 << r_grant)
                                                : {NUM_REQ{1'b0}};
    end
  end

  assign alu_a         = r_op_a;
  assign alu_b         = r_op_b;
  assign alu_op        = r_op;
  assign alu_valid     = r_alu_valid;
  assign alu_res_ready = r_alu_res_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_res;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched
//   Self-checking bench for alu_sched: a behavioural ALU with random
//   handshake latency, a transaction-level scheduler model (one outstanding
//   op, owner, round-robin pointer) compared every cycle, directed vector
//   table, hand-written corner sequences and a randomized phase.
module tb_alu_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][W-1:0] req_a = '0;
  logic [N-1:0][W-1:0] req_b = '0;
  logic [N-1:0]      req_op = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '1;
  logic [W-1:0]      rsp_data;
  logic [W-1:0]      alu_a, alu_b;
  logic              alu_op, alu_valid;
  logic              alu_ready = 1'b0;
  logic [W-1:0]      alu_result = '0;
  logic              alu_res_valid = 1'b0;
  logic              alu_res_ready;

  alu_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_result(alu_result), .alu_res_valid(alu_res_valid),
    .alu_res_ready(alu_res_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- single-precision arithmetic via real ----------------
  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_alu(input logic [31:0] a, input logic [31:0] b, input logic op);
    real ra, rb;
    ra = sp2real(a);
    rb = sp2real(b);
    return op ? real2sp(ra * rb) : real2sp(ra + rb);
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT at t=%0t", nm, $time);
  endfunction

  // ---------------- behavioural ALU: one op, random latency ----------------
  bit          alu_hold = 1'b0;
  bit          a_rst = 1'b1, a_iss = 1'b0, a_ret = 1'b0, a_busy = 1'b0;
  int          a_cnt = 0;
  logic [31:0] a_la, a_lb, a_res;
  logic        a_lop;

  always begin
    @(posedge clk);
    #2;
    if (a_rst) begin
      a_busy = 1'b0;
      alu_res_valid = 1'b0;
      alu_ready = 1'b0;
    end else begin
      if (a_ret) begin
        alu_res_valid = 1'b0;
        a_busy = 1'b0;
      end
      if (a_iss) begin
        a_busy = 1'b1;
        a_res = fp_alu(a_la, a_lb, a_lop);
        a_cnt = $urandom_range(0, 3);
      end
      if (a_busy && !alu_res_valid && !alu_hold) begin
        if (a_cnt == 0) begin
          alu_res_valid = 1'b1;
          alu_result = a_res;
        end else begin
          a_cnt--;
        end
      end
      if (!alu_res_valid) alu_result = $urandom;
      alu_ready = !a_busy && ($urandom_range(0, 3) != 0);
    end
    // inputs and registered DUT outputs are now stable until the next edge
    a_rst = reset;
    a_iss = alu_valid && alu_ready;
    a_ret = alu_res_valid && alu_res_ready;
    a_la = alu_a;
    a_lb = alu_b;
    a_lop = alu_op;
  end

  // ---------------- transaction-level scheduler model ----------------
  bit          m_out = 1'b0, m_issued = 1'b0, m_done = 1'b0;
  int          m_owner = 0, m_ptr = 0;
  logic [31:0] m_a, m_b, m_exp;
  logic        m_op;
  int          served[$];
  int          n_resp = 0;
  int          last_idx = -1;
  logic [31:0] last_data = '0;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Check one cycle at the falling edge, then advance the model past the rising edge
  task automatic tick();
    logic [N-1:0] exp_rdy, exp_rv;
    int g;
    @(negedge clk);
    if (reset) begin
      m_out = 1'b0; m_issued = 1'b0; m_done = 1'b0; m_ptr = 0;
    end else begin
      g = pick(req_valid, m_ptr);
      exp_rdy = (!m_out && g >= 0) ? oh(g) : '0;
      exp_rv  = (m_out && m_done) ? oh(m_owner) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("alu_valid", 32'(alu_valid), 32'(m_out && !m_issued));
      chk("alu_res_ready", 32'(alu_res_ready), 32'(m_out && m_issued && !m_done));
      if (m_out && !m_issued) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", 32'(alu_op), 32'(m_op));
      end
      if (m_out && m_done) chk("rsp_data", rsp_data, m_exp);
      if (!m_out) begin
        if (g >= 0) begin
          m_out = 1'b1; m_owner = g;
          m_a = req_a[g]; m_b = req_b[g]; m_op = req_op[g];
          m_exp = fp_alu(m_a, m_b, m_op);
        end
      end else if (!m_issued) begin
        if (alu_ready) m_issued = 1'b1;
      end else if (!m_done) begin
        if (alu_res_valid) m_done = 1'b1;
      end else if (rsp_ready[m_owner]) begin
        served.push_back(m_owner);
        last_idx = m_owner;
        last_data = rsp_data;
        n_resp++;
        m_ptr = (m_owner + 1) % N;
        m_out = 1'b0; m_issued = 1'b0; m_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp, input string nm);
    int start, budget;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx] = a; req_b[idx] = b; req_op[idx] = op;
    rsp_ready = '1;
    start = n_resp;
    budget = 0;
    while (!m_out && budget < 50) begin tick(); budget++; end
    req_valid = '0;
    while (n_resp == start && budget < 150) begin tick(); budget++; end
    if (n_resp == start) tmo(nm);
    else begin
      chk({nm, "_grant"}, 32'(last_idx), 32'(idx));
      chk({nm, "_data"}, last_data, exp);
    end
  endtask

  task automatic drain(input string nm);
    int budget;
    req_valid = '0;
    rsp_ready = '1;
    budget = 0;
    while (m_out && budget < 150) begin tick(); budget++; end
    if (m_out) tmo(nm);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget, resp0;
    int exp_order[5];

    // 1+2=3 (req 1), 2*3=6 (req 3), 10+(-4)=6 (req 2), 5*0.5=2.5 (req 0, wraps from ptr 3)
    tbl[0] = '{1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    tbl[1] = '{3, 32'h40000000, 32'h40400000, 1'b1, 32'h40C00000};
    tbl[2] = '{2, 32'h41200000, 32'hC0800000, 1'b0, 32'h40C00000};
    tbl[3] = '{0, 32'h40A00000, 32'h3F000000, 1'b1, 32'h40200000};
    exp_order = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);

    // directed vectors
    for (int i = 0; i < 4; i++)
      run_one(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, $sformatf("vec%0d", i));

    // pointer now 1: with requesters 0 and 1 valid, 1 must win
    req_valid = 4'b0011;
    #1;
    chk("wrap_ptr_ready", 32'(req_ready), 32'h2);
    tick();
    drain("wrap_drain");

    // contention from reset: all four valid continuously
    served.delete();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = rnd_fp(); req_b[i] = rnd_fp(); req_op[i] = 1'(i);
    end
    req_valid = '1;
    tick(); tick();
    reset = 1'b0;
    budget = 0;
    while (served.size() < 5 && budget < 400) begin tick(); budget++; end
    req_valid = '0;
    for (int k = 0; k < 5; k++)
      chk($sformatf("order%0d", k), 32'((k < served.size()) ? served[k] : -1), 32'(exp_order[k]));
    drain("cont_drain");

    // backpressure on requester 2 (pointer is 1 here)
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    req_a[2] = 32'h40400000; req_b[2] = 32'h40800000; req_op[2] = 1'b1;
    budget = 0;
    while (!m_done && budget < 100) begin tick(); budget++; end
    if (!m_done) tmo("bp_wait");
    req_valid = 4'b0001;
    req_a[0] = rnd_fp(); req_b[0] = rnd_fp(); req_op[0] = 1'b0;
    repeat (10) tick();
    chk("bp_hold_valid", 32'(rsp_valid), 32'h4);
    chk("bp_hold_data", rsp_data, 32'h41400000);
    rsp_ready = '1;
    tick();
    chk("bp_release_data", last_data, 32'h41400000);
    chk("bp_next_grant", 32'(req_ready), 32'h1);
    tick();
    drain("bp_drain");

    // reset while waiting on the ALU
    alu_hold = 1'b1;
    req_valid = 4'b0010;
    req_a[1] = tbl[0].a; req_b[1] = tbl[0].b; req_op[1] = tbl[0].op;
    budget = 0;
    while (!m_issued && budget < 50) begin tick(); budget++; end
    if (!m_issued) tmo("rw_issue");
    req_valid = '0;
    repeat (2) tick();
    chk("rw_in_wait", 32'(alu_res_ready), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_alu_valid", 32'(alu_valid), 32'd0);
    chk("rw_alu_res_ready", 32'(alu_res_ready), 32'd0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_rsp_data", rsp_data, 32'd0);
    chk("rw_alu_ab", alu_a | alu_b, 32'd0);
    chk("rw_alu_op", 32'(alu_op), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd0);
    alu_hold = 1'b0;
    resp0 = n_resp;
    repeat (5) tick();
    chk("rw_no_resp", 32'(n_resp), 32'(resp0));
    run_one(tbl[1].idx, tbl[1].a, tbl[1].b, tbl[1].op, tbl[1].exp, "rw_fresh");

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_a[i] = rnd_fp();
        req_b[i] = rnd_fp();
        req_op[i] = 1'($urandom);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
